// File: rtl/int_pkg.sv
// Shared types for the interrupt status block: register map and source vector.
package int_pkg;

  localparam int unsigned NSRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    ADDR_STATUS  = 2'd0,
    ADDR_INTEN   = 2'd1,
    ADDR_PENDING = 2'd2,
    ADDR_SWSET   = 2'd3
  } reg_addr_t;

  typedef logic [NSRC_DEFAULT-1:0] irq_vec_t;

endpackage

// File: rtl/int_edge_sync.sv
// Per-bit input conditioning and rising-edge detect for interrupt sources.
// Define INT_STATUS_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module int_edge_sync
  import int_pkg::*;
#(
  parameter int unsigned W = NSRC_DEFAULT
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [W-1:0] irq_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

`ifdef INT_STATUS_SYNC_EN
  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_o = sync2_q;
`else
  assign level_o = irq_i;
`endif

  // prev resets low so a source already high at reset release yields one edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= level_o;
    end
  end

  assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/int_status_regs.sv
// Sticky interrupt status, enable mask and CPU register bus feeding the combiner.
// Build option INT_STATUS_SYNC_EN selects the synchronized source path in int_edge_sync.
module int_status_regs
  import int_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_in,
  input  logic [1:0]      addr,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [NSRC-1:0] wdata,
  output logic [NSRC-1:0] rdata,
  output logic [NSRC-1:0] statout,
  output logic [NSRC-1:0] intout,
  output logic            irq_any
);

  logic [NSRC-1:0] status_q, status_d;
  logic [NSRC-1:0] inten_q, inten_d;
  logic [NSRC-1:0] rdata_q, rdata_d;
  logic            irq_any_q, irq_any_d;
  logic [NSRC-1:0] level;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  reg_addr_t       sel;

  int_edge_sync #(
    .W (NSRC)
  ) u_edge_sync (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .irq_i     (irq_in),
    .level_o   (level),
    .rise_o    (rise)
  );

  assign sel     = reg_addr_t'(addr);
  assign pending = status_q & inten_q;

  // Edges are OR-ed in after any clear so a same-cycle W1C never drops a new event.
  always_comb begin
    status_d  = status_q | rise;
    inten_d   = inten_q;
    rdata_d   = rdata_q;
    irq_any_d = |pending;
    if (wr_en) begin
      case (sel)
        ADDR_STATUS: status_d = (status_q & ~wdata) | rise;
        ADDR_INTEN:  inten_d  = wdata;
        ADDR_SWSET:  status_d = status_q | wdata | rise;
        default:     ;
      endcase
    end
    if (rd_en) begin
      case (sel)
        ADDR_STATUS:  rdata_d = status_q;
        ADDR_INTEN:   rdata_d = inten_q;
        ADDR_PENDING: rdata_d = pending;
        ADDR_SWSET:   rdata_d = level;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q  <= '0;
      inten_q   <= '0;
      rdata_q   <= '0;
      irq_any_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      inten_q   <= inten_d;
      rdata_q   <= rdata_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign statout = status_q;
  assign intout  = inten_q;
  assign rdata   = rdata_q;
  assign irq_any = irq_any_q;

endmodule

// File: doc/int_status_regs.md
Name: int_status_regs

Overview:
- Upstream feeder for the interrupt combiner. Latches 8 external interrupt sources into a sticky status register and holds a software-programmed enable mask.
- Drives statout/intout straight into the combiner; exposes a simple register bus for the CPU.
- All state is registered; only the edge-detect term and the pending AND are combinational.

Parameters:
- NSRC, 8, number of interrupt sources; the status, enable and data-bus widths all equal NSRC.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- irq_in  in  NSRC  raw interrupt sources, asynchronous to clk.
- addr  in  2  register select: 0 STATUS, 1 INTEN, 2 PENDING, 3 SWSET.
- wr_en  in  1  write strobe, single cycle.
- rd_en  in  1  read strobe, single cycle.
- wdata  in  NSRC  write data.
- rdata  out  NSRC  registered read data.
- statout  out  NSRC  sticky status, to combiner.
- intout  out  NSRC  enable mask, to combiner.
- irq_any  out  1  registered OR of (status & inten).

Behaviour:
- Reset (async on reset_n low): status, inten, rdata, irq_any, synchronizer flops and edge-history flops all go to 0. Outputs are 0 while reset_n is low.
- Synchronizer: 2 flops per bit (sync1 -> sync2). prev holds sync2 delayed by one cycle.
- Edge detect: rise[i] = sync2[i] & ~prev[i]. Only rising edges set status; level-high alone never re-sets a cleared bit.
- Edge latency: irq_in[i] goes high before edge E0 -> statout[i] is 1 after E2.
- A source already high at reset release sets its status once (prev reset to 0).
- Pulse width: irq_in pulses shorter than one clk period may be lost; sources must hold for at least 2 cycles.
- STATUS write (addr 0): write-1-to-clear. status <= (status & ~wdata) | rise. Set wins over clear in the same cycle, so no edge is lost.
- INTEN write (addr 1): inten <= wdata, effective the next cycle.
- PENDING (addr 2): read-only, value = status & inten. Writes are ignored.
- SWSET write (addr 3): status <= status | wdata | rise (software trigger). A read of SWSET returns sync2 (raw synchronized levels).
- Reads:
  - rdata is updated one cycle after rd_en and holds its value until the next rd_en.
  - rd_en and wr_en in the same cycle: rdata returns the pre-write value.
- irq_any = |(status & inten), registered. It asserts one cycle after statout/intout make the AND non-zero and deasserts one cycle after clear.
- Bus strobe rules: wr_en and rd_en are single-cycle, with no wait states and no error response. Addr is decoded only when a strobe is high.
- statout and intout are driven directly from the status and inten registers, with no added latency.
- Reset mid-operation: all state clears immediately. In-flight edges are discarded. A source still high after release re-latches per the reset-release rule.

Optional Feature:
- Macro: INT_STATUS_SYNC_EN.
- Defined: 2-flop synchronizer present; edge latency is 2 cycles as above.
- Undefined: synchronizer removed and irq_in is treated as synchronous to clk. prev samples irq_in directly and rise = irq_in & ~prev, so statout is set at E0 (latency 0 edges after the sampling edge).
- All register-bus behaviour is identical in both builds.

Decomposition:
- Shared package int_pkg:
  - NSRC_DEFAULT = 8.
  - Register-address enum reg_addr_t {ADDR_STATUS=0, ADDR_INTEN=1, ADDR_PENDING=2, ADDR_SWSET=3}.
  - typedef logic [NSRC-1:0] irq_vec_t.
- One natural sub-module: int_edge_sync. It holds the per-bit synchronizer (macro-gated), the prev flop and the rise output, and is instantiated once with vector width NSRC.
- The register file and bus decode stay in int_status_regs.

Test Plan:
- Reset: hold reset_n=0 with irq_in=8'hFF. Release: statout=8'hFF after 2 cycles (sync build), intout=0, irq_any=0. Drop irq_in to 0 and clear: status stays 0.
- Edge latch: irq_in[3] rises at E0 with inten=8'h08. statout=8'h08 after E2, irq_any=1 after E3. Hold irq_in[3] high, W1C 8'h08: status=0 and stays 0.
- Simultaneous set/clear: W1C 8'h01 in the exact cycle rise[0]=1 -> status[0] remains 1.
- Bus:
  - Write INTEN 8'hA5; read addr 1 -> rdata=8'hA5 one cycle later.
  - Status 8'h0F: read PENDING -> 8'h05.
  - Write PENDING 8'hFF -> no state change.
- SWSET: write addr 3 with 8'h80 and irq_in=0 -> statout=8'h80 next cycle. Read addr 3 -> rdata=8'h00.
- Reset mid-operation: status 8'h3C, inten 8'hFF, irq_any=1. Pulse reset_n low asynchronously between edges -> all outputs 0 immediately, no clk edge required.
